instr_ctrl: RTL and testbench
=============================

INSTR_CTRL -- requirements
Module: instr_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: mem_addr  out  8  byte address to unified memory; mem_rdata  in  8  combinational read data for mem_addr.
REQ-004 SHALL have ports: mem_we  out  1  memory write strobe; mem_wdata  out  8  store data (= rd2).
REQ-005 SHALL have ports: a1, a2, a3  out  4 each  register-file read/read/write addresses; we3  out  1  register write enable; wd3  out  8  register write data.
REQ-006 SHALL have ports: rd1, rd2  in  8 each  register-file read data; alu_op  out  2  (00 ADD, 01 SUB, 10 AND, 11 OR); alu_result  in  8.
REQ-007 SHALL have ports: pc  out  8  program counter; halted  out  1  core stopped; trap  out  1  illegal opcode seen (macro-dependent).

Function
REQ-008 Instruction is 16 bits, big-endian in memory: op=IR[15:12], rd=IR[11:8], rs1=IR[7:4], rs2=IR[3:0], imm8=IR[7:0].
REQ-009 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LDI, 6 LD (rd<=mem[rs1]), 7 ST (mem[rs1]<=rd), 8 BEQZ (pc<=imm8 if Z), 9 JMP (pc<=imm8), F HALT; A-E illegal.
REQ-010 FSM states: FETCH_HI, FETCH_LO, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-011 FETCH_HI: mem_addr=pc; IR[15:8]<=mem_rdata; pc<=pc+1 (mod 256); -> FETCH_LO.
REQ-012 FETCH_LO: mem_addr=pc; IR[7:0]<=mem_rdata; pc<=pc+1 (mod 256); -> DECODE.
REQ-013 DECODE and EXECUTE: a1=rs1; a2=rd for ST, else rs2; DECODE -> EXECUTE unconditionally.
REQ-014 EXECUTE, ADD-OR: alu_op=op-1; ALUOUT<=alu_result; Z<=(alu_result==0); -> WRITEBACK.
REQ-015 EXECUTE, LDI: ALUOUT<=imm8; Z unchanged; -> WRITEBACK.
REQ-016 EXECUTE, LD: mem_addr=rd1; ALUOUT<=mem_rdata; -> WRITEBACK.
REQ-017 EXECUTE, ST: mem_addr=rd1, mem_wdata=rd2, mem_we=1 for exactly this cycle; -> FETCH_HI.
REQ-018 EXECUTE, BEQZ: pc<=imm8 if Z=1 else unchanged; JMP: pc<=imm8; NOP: no effect; all -> FETCH_HI.
REQ-019 EXECUTE, HALT: -> HALT; halted=1; HALT state is absorbing until reset.
REQ-020 WRITEBACK: we3=1, a3=rd, wd3=ALUOUT for exactly one cycle; -> FETCH_HI.
REQ-021 we3 and mem_we SHALL be 0 in every state/case not listed above; never both 1 in one cycle.
REQ-022 Cycle counts: ALU/LDI/LD = 5 cycles; ST/BEQZ/JMP/NOP = 4 cycles.
REQ-023 pc wraps 0xFF->0x00; an instruction may straddle the wrap (hi byte at 0xFF, lo at 0x00).
REQ-024 In non-EXECUTE states mem_addr=pc; mem_wdata=rd2 at all times.
REQ-025 Write to rd==rs1 in an instruction: read uses pre-write value (write occurs at end of WRITEBACK).

Reset
REQ-026 reset_n low SHALL immediately force: state=FETCH_HI, pc=0x00, IR=0x0000, ALUOUT=0x00, Z=0, halted=0, trap=0, we3=0, mem_we=0.
REQ-027 Reset asserted mid-instruction (including WRITEBACK or ST EXECUTE) SHALL abort it with no write; release restarts fetch at 0x00 on first rising edge.
REQ-028 Reset SHALL exit HALT.

Configuration
REQ-029 Macro ILLEGAL_TRAP_EN: when defined, illegal opcode in EXECUTE -> HALT with halted=1 and trap=1 (sticky until reset).
REQ-030 Without ILLEGAL_TRAP_EN: illegal opcodes execute as NOP (4 cycles), trap tied to 0.

Verification
REQ-031 LDI r1,0x05; LDI r2,0x03; SUB r3,r1,r2 -> we3 pulses at cycles 5,10,15 with (a3,wd3)=(1,05),(2,03),(3,02); Z=0.
REQ-032 LDI r1,0x07; ST r1->[r1]; LD r4,[r1] -> mem_we one cycle with mem_addr=07, wd=07; then a3=4, wd3=07.
REQ-033 SUB r5,r1,r1 (Z=1); BEQZ 0x40 -> pc=0x40 next FETCH_HI; with Z=0 pc=sequential address.
REQ-034 pc=0xFF start, JMP 0x10 straddling wrap -> IR=0x9010 fetched from 0xFF/0x00; pc=0x10.
REQ-035 opcode 0xA: with ILLEGAL_TRAP_EN halted=1, trap=1, no further fetch; without, 4-cycle NOP, trap=0.
REQ-036 reset_n low during WRITEBACK of ADD -> we3 drops immediately, register unchanged, pc=0x00 after release.

Source files
------------

// File: rtl/instr_ctrl.sv
// Multi-cycle control unit for a 16-bit-instruction, 8-bit-data core with a unified byte memory.
// Optional feature: define ILLEGAL_TRAP_EN to halt with a sticky trap flag on opcodes 0xA-0xE.
module instr_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    output logic [3:0] a1,
    output logic [3:0] a2,
    output logic [3:0] a3,
    output logic       we3,
    output logic [7:0] wd3,
    input  logic [7:0] rd1,
    input  logic [7:0] rd2,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_result,
    output logic [7:0] pc,
    output logic       halted,
    output logic       trap
);

    typedef enum logic [2:0] {
        S_FETCH_HI,
        S_FETCH_LO,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;
    logic [7:0]  r_aluout;
    logic        r_z;
    logic        r_halted;
    logic        r_we3;
    logic        r_mem_we;

    logic [3:0]  w_op;
    logic [3:0]  w_rd;
    logic [3:0]  w_rs1;
    logic [3:0]  w_rs2;
    logic [7:0]  w_imm;
    logic        w_mem_op;

    assign w_op  = r_ir[15:12];
    assign w_rd  = r_ir[11:8];
    assign w_rs1 = r_ir[7:4];
    assign w_rs2 = r_ir[3:0];
    assign w_imm = r_ir[7:0];

    // Only LD/ST in EXECUTE steer the memory port away from the program counter.
    assign w_mem_op  = (r_state == S_EXECUTE) && ((w_op == OP_LD) || (w_op == OP_ST));
    assign mem_addr  = w_mem_op ? rd1 : r_pc;
    assign mem_wdata = rd2;
    assign mem_we    = r_mem_we;

    assign a1  = w_rs1;
    assign a2  = (w_op == OP_ST) ? w_rd : w_rs2;
    assign a3  = w_rd;
    assign wd3 = r_aluout;
    assign we3 = r_we3;

    assign pc     = r_pc;
    assign halted = r_halted;

    always_comb begin
        alu_op = 2'b00;
        case (w_op)
            OP_ADD:  alu_op = 2'b00;
            OP_SUB:  alu_op = 2'b01;
            OP_AND:  alu_op = 2'b10;
            OP_OR:   alu_op = 2'b11;
            default: alu_op = 2'b00;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_trap;
    logic w_illegal;

    assign w_illegal = (w_op >= 4'hA) && (w_op <= 4'hE);
    assign trap      = r_trap;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_FETCH_HI;
            r_pc     <= 8'h00;
            r_ir     <= 16'h0000;
            r_aluout <= 8'h00;
            r_z      <= 1'b0;
            r_halted <= 1'b0;
            r_we3    <= 1'b0;
            r_mem_we <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            r_trap   <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle: raised on entry to their state, dropped on the next edge.
            r_we3    <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                S_FETCH_HI: begin
                    r_ir[15:8] <= mem_rdata;
                    r_pc       <= r_pc + 8'd1;
                    r_state    <= S_FETCH_LO;
                end
                S_FETCH_LO: begin
                    r_ir[7:0] <= mem_rdata;
                    r_pc      <= r_pc + 8'd1;
                    r_state   <= S_DECODE;
                end
                S_DECODE: begin
                    r_mem_we <= (w_op == OP_ST);
                    r_state  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (w_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            r_aluout <= alu_result;
                            r_z      <= (alu_result == 8'h00);
                            r_we3    <= 1'b1;
                            r_state  <= S_WRITEBACK;
                        end
                        OP_LDI: begin
                            r_aluout <= w_imm;
                            r_we3    <= 1'b1;
                            r_state  <= S_WRITEBACK;
                        end
                        OP_LD: begin
                            r_aluout <= mem_rdata;
                            r_we3    <= 1'b1;
                            r_state  <= S_WRITEBACK;
                        end
                        OP_BEQZ: begin
                            if (r_z) r_pc <= w_imm;
                            r_state <= S_FETCH_HI;
                        end
                        OP_JMP: begin
                            r_pc    <= w_imm;
                            r_state <= S_FETCH_HI;
                        end
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        OP_NOP, OP_ST: begin
                            r_state <= S_FETCH_HI;
                        end
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            if (w_illegal) begin
                                r_halted <= 1'b1;
                                r_trap   <= 1'b1;
                                r_state  <= S_HALT;
                            end else begin
                                r_state <= S_FETCH_HI;
                            end
`else
                            r_state <= S_FETCH_HI;
`endif
                        end
                    endcase
                end
                S_WRITEBACK: begin
                    r_state <= S_FETCH_HI;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_ctrl.sv
// Directed bench for instr_ctrl: models memory, register file and ALU around the controller.
module tb_instr_ctrl;

    logic       clk;
    logic       reset_n;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [3:0] a1;
    logic [3:0] a2;
    logic [3:0] a3;
    logic       we3;
    logic [7:0] wd3;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic [7:0] pc;
    logic       halted;
    logic       trap;

    logic [7:0] mem [0:255];
    logic [7:0] rf  [0:15];

    int n_pass;
    int n_tot;
    int cyc;
    int both_cnt;
    logic [7:0] ma_log [0:63];
    logic [7:0] pc_log [0:63];
    logic [3:0] a1_log [0:63];
    int         w_cyc [$];
    logic [3:0] w_a   [$];
    logic [7:0] w_d   [$];
    int         m_cyc [$];
    logic [7:0] m_a   [$];
    logic [7:0] m_d   [$];

    instr_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .we3       (we3),
        .wd3       (wd3),
        .rd1       (rd1),
        .rd2       (rd2),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .pc        (pc),
        .halted    (halted),
        .trap      (trap)
    );

    assign mem_rdata = mem[mem_addr];
    assign rd1 = rf[a1];
    assign rd2 = rf[a2];

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            2'b00: alu_result = rd1 + rd2;
            2'b01: alu_result = rd1 - rd2;
            2'b10: alu_result = rd1 & rd2;
            2'b11: alu_result = rd1 | rd2;
            default: alu_result = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tot = n_tot + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: sample mid-cycle, then commit any memory/register write after the edge.
    task automatic step();
        logic       s_we3, s_mwe;
        logic [3:0] s_a3;
        logic [7:0] s_wd3, s_ma, s_md;
        @(negedge clk);
        cyc = cyc + 1;
        s_we3 = we3; s_a3 = a3; s_wd3 = wd3;
        s_mwe = mem_we; s_ma = mem_addr; s_md = mem_wdata;
        if (cyc < 64) begin
            ma_log[cyc] = mem_addr;
            pc_log[cyc] = pc;
            a1_log[cyc] = a1;
        end
        if (s_we3 === 1'b1) begin
            w_cyc.push_back(cyc); w_a.push_back(s_a3); w_d.push_back(s_wd3);
        end
        if (s_mwe === 1'b1) begin
            m_cyc.push_back(cyc); m_a.push_back(s_ma); m_d.push_back(s_md);
        end
        if ((s_we3 === 1'b1) && (s_mwe === 1'b1)) both_cnt = both_cnt + 1;
        @(posedge clk);
        #1;
        if (s_we3 === 1'b1) rf[s_a3] = s_wd3;
        if (s_mwe === 1'b1) mem[s_ma] = s_md;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic hold_reset();
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        w_cyc.delete(); w_a.delete(); w_d.delete();
        m_cyc.delete(); m_a.delete(); m_d.delete();
    endtask

    initial begin
        n_pass = 0; n_tot = 0; cyc = 0; both_cnt = 0;
        reset_n = 1'b0;

        // LDI r1,05 ; LDI r2,03 ; SUB r3,r1,r2 ; HALT
        hold_reset();
        mem[0] = 8'h51; mem[1] = 8'h05; mem[2] = 8'h52; mem[3] = 8'h03;
        mem[4] = 8'h23; mem[5] = 8'h12; mem[6] = 8'hF0; mem[7] = 8'h00;
        @(posedge clk); #1;
        chk("rst_pc", {8'h0, pc}, 16'h0000);
        chk("rst_we3", {15'h0, we3}, 16'h0000);
        chk("rst_mem_we", {15'h0, mem_we}, 16'h0000);
        chk("rst_halted", {15'h0, halted}, 16'h0000);
        chk("rst_trap", {15'h0, trap}, 16'h0000);
        chk("rst_mem_addr", {8'h0, mem_addr}, 16'h0000);
        release_reset();
        steps(21);
        chk("A_we3_count", 16'(w_cyc.size()), 16'd3);
        if (w_cyc.size() == 3) begin
            chk("A_wb0_cyc", 16'(w_cyc[0]), 16'd5);
            chk("A_wb0", {4'h0, w_a[0], w_d[0]}, 16'h0105);
            chk("A_wb1_cyc", 16'(w_cyc[1]), 16'd10);
            chk("A_wb1", {4'h0, w_a[1], w_d[1]}, 16'h0203);
            chk("A_wb2_cyc", 16'(w_cyc[2]), 16'd15);
            chk("A_wb2", {4'h0, w_a[2], w_d[2]}, 16'h0302);
        end
        chk("A_halted", {15'h0, halted}, 16'h0001);
        chk("A_trap", {15'h0, trap}, 16'h0000);
        chk("A_pc_halt", {8'h0, pc}, 16'h0008);
        chk("A_no_mem_we", 16'(m_cyc.size()), 16'd0);

        // LDI r1,07 ; ST r1->[r1] ; LD r4,[r1] ; HALT (store overwrites the HALT low byte)
        hold_reset();
        mem[0] = 8'h51; mem[1] = 8'h07; mem[2] = 8'h71; mem[3] = 8'h10;
        mem[4] = 8'h64; mem[5] = 8'h10; mem[6] = 8'hF0; mem[7] = 8'h00;
        release_reset();
        steps(20);
        chk("B_mem_we_count", 16'(m_cyc.size()), 16'd1);
        if (m_cyc.size() == 1) begin
            chk("B_st_cyc", 16'(m_cyc[0]), 16'd9);
            chk("B_st_addr_data", {m_a[0], m_d[0]}, 16'h0707);
        end
        chk("B_we3_count", 16'(w_cyc.size()), 16'd2);
        if (w_cyc.size() == 2) begin
            chk("B_ld_cyc", 16'(w_cyc[1]), 16'd14);
            chk("B_ld_wb", {4'h0, w_a[1], w_d[1]}, 16'h0407);
        end
        chk("B_mem7", {8'h0, mem[7]}, 16'h0007);
        chk("B_halted", {15'h0, halted}, 16'h0001);

        // LDI r1,09 ; SUB r5,r1,r1 ; BEQZ 40 (taken) ; @40: LDI r2,01 ; ADD r6,r2,r0 ; BEQZ 80 (not taken) ; HALT
        hold_reset();
        mem[0] = 8'h51; mem[1] = 8'h09; mem[2] = 8'h25; mem[3] = 8'h11;
        mem[4] = 8'h80; mem[5] = 8'h40;
        mem[8'h40] = 8'h52; mem[8'h41] = 8'h01; mem[8'h42] = 8'h16; mem[8'h43] = 8'h20;
        mem[8'h44] = 8'h80; mem[8'h45] = 8'h80; mem[8'h46] = 8'hF0; mem[8'h47] = 8'h00;
        release_reset();
        steps(34);
        chk("C_beqz_taken", {8'h0, ma_log[15]}, 16'h0040);
        chk("C_beqz_not_taken", {8'h0, ma_log[29]}, 16'h0046);
        chk("C_r5", {8'h0, rf[5]}, 16'h0000);
        chk("C_r6", {8'h0, rf[6]}, 16'h0001);
        chk("C_halted", {15'h0, halted}, 16'h0001);

        // ADD r0,r0,r0 ; JMP FF ; JMP 10 straddling FF/00 ; @10: HALT
        hold_reset();
        mem[0] = 8'h10; mem[1] = 8'h00; mem[2] = 8'h90; mem[3] = 8'hFF;
        mem[8'hFF] = 8'h90; mem[8'h10] = 8'hF0; mem[8'h11] = 8'h00;
        release_reset();
        steps(19);
        chk("D_fetch_hi_ff", {8'h0, ma_log[10]}, 16'h00FF);
        chk("D_fetch_lo_00", {8'h0, ma_log[11]}, 16'h0000);
        chk("D_pc_wrapped", {8'h0, pc_log[12]}, 16'h0001);
        chk("D_ir_rs1", {12'h0, a1_log[12]}, 16'h0001);
        chk("D_jmp_target", {8'h0, ma_log[14]}, 16'h0010);
        chk("D_halted", {15'h0, halted}, 16'h0001);

        // Illegal opcode A ; LDI r1,0C ; HALT
        hold_reset();
        mem[0] = 8'hA5; mem[1] = 8'h55; mem[2] = 8'h51; mem[3] = 8'h0C;
        mem[4] = 8'hF0; mem[5] = 8'h00;
        release_reset();
        steps(9);
        chk("E_addr_cyc5", {8'h0, ma_log[5]}, 16'h0002);
`ifdef ILLEGAL_TRAP_EN
        chk("E_halted", {15'h0, halted}, 16'h0001);
        chk("E_trap", {15'h0, trap}, 16'h0001);
        chk("E_pc_frozen", {8'h0, pc}, 16'h0002);
        chk("E_no_we3", 16'(w_cyc.size()), 16'd0);
`else
        chk("E_halted", {15'h0, halted}, 16'h0000);
        chk("E_trap", {15'h0, trap}, 16'h0000);
        chk("E_we3_count", 16'(w_cyc.size()), 16'd1);
        if (w_cyc.size() == 1) begin
            chk("E_ldi_cyc", 16'(w_cyc[0]), 16'd9);
            chk("E_ldi_wb", {4'h0, w_a[0], w_d[0]}, 16'h010C);
        end
`endif
        chk("E_no_mem_we", 16'(m_cyc.size()), 16'd0);

        // ADD r3,r1,r2 aborted by reset during WRITEBACK
        hold_reset();
        rf[1] = 8'h04; rf[2] = 8'h05; rf[3] = 8'hAA;
        mem[0] = 8'h13; mem[1] = 8'h12; mem[2] = 8'hF0; mem[3] = 8'h00;
        release_reset();
        steps(4);
        chk("F_wb_we3", {15'h0, we3}, 16'h0001);
        chk("F_wb_data", {4'h0, a3, wd3}, 16'h0309);
        reset_n = 1'b0;
        #1;
        chk("F_abort_we3", {15'h0, we3}, 16'h0000);
        chk("F_abort_pc", {8'h0, pc}, 16'h0000);
        release_reset();
        chk("F_r3_unchanged", {8'h0, rf[3]}, 16'h00AA);
        steps(5);
        chk("F_restart_addr", {8'h0, ma_log[1]}, 16'h0000);
        chk("F_rerun_we3_cyc", 16'(w_cyc.size() == 1 ? w_cyc[0] : 0), 16'd5);
        chk("F_r3_written", {8'h0, rf[3]}, 16'h0009);

        chk("never_both_strobes", 16'(both_cnt), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
